// File: rtl/tqvp_hx2003_pulse_transmitter_gen2.sv
`timescale 1ns/1ps
// TinyQV pulse-train peripheral (gen2): plays 2-bit symbols from DATA memory on uo_out[2],
// each symbol timed from a main or auxiliary duration table, with optional carrier.
module tqvp_hx2003_pulse_transmitter_gen2 #(
  parameter int DEPTH_WORDS = 8,
  parameter int DUR_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int PCW = $clog2(DEPTH_WORDS * 16);
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int TW  = DUR_W + 16;

  typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;

  // Configuration registers
  logic [6:0]     ctrl_q;
  logic [PCW-1:0] end_pc_q, loop_pc_q;
  logic [7:0]     repeat_q;
  logic [3:0]     main_presc_q, aux_presc_q;
  logic [15:0]    half_period_q;
  logic [7:0]     aux_mask_q;
  logic [31:0]    main_low_q, main_high_q, aux_low_q, aux_high_q;
  logic [31:0]    mem_q [DEPTH_WORDS];

  // Sequencer state
  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [7:0]     loops_left_q, loops_left_d;
  logic           level_q, level_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           start_prev_q;
  logic           done_q, loop_q;
  logic [15:0]    car_cnt_q;
  logic           car_q;

  logic           wr_en, wr_status, wr_data;
  logic [3:0]     reg_sel;
  logic           start, start_edge, busy;
  logic           set_done, set_loop, start_clr;
  logic           clr_done, clr_loop;

  assign wr_en      = (data_write_n == 2'b10);
  assign reg_sel    = address[5:2];
  assign wr_status  = wr_en && (reg_sel == 4'd7);
  assign wr_data    = wr_en && address[5];
  assign clr_done   = wr_status && data_in[1];
  assign clr_loop   = wr_status && data_in[2];
  assign start      = ctrl_q[0];
  assign start_edge = start && !start_prev_q;
  assign busy       = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q        <= '0;
      end_pc_q      <= '0;
      loop_pc_q     <= '0;
      repeat_q      <= '0;
      main_presc_q  <= '0;
      aux_presc_q   <= '0;
      half_period_q <= '0;
      aux_mask_q    <= '0;
      main_low_q    <= '0;
      main_high_q   <= '0;
      aux_low_q     <= '0;
      aux_high_q    <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        4'd0: ctrl_q <= data_in[6:0];
        4'd1: begin
          end_pc_q     <= data_in[PCW-1:0];
          loop_pc_q    <= data_in[8 +: PCW];
          repeat_q     <= data_in[23:16];
          main_presc_q <= data_in[27:24];
          aux_presc_q  <= data_in[31:28];
        end
        4'd2: begin
          half_period_q <= data_in[15:0];
          aux_mask_q    <= data_in[23:16];
        end
        4'd3: main_low_q  <= data_in;
        4'd4: main_high_q <= data_in;
        4'd5: aux_low_q   <= data_in;
        4'd6: aux_high_q  <= data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_data) begin
      mem_q[address[AW+1:2]] <= data_in;
    end
  end

  // Symbol lookup: FETCH reads the current pc, RUN looks ahead to the successor
  // so the next symbol is loaded on the expiry edge with no idle gap.
  logic           at_end, do_loop;
  logic [PCW-1:0] pc_adv, fetch_pc;
  logic [31:0]    fetch_word;
  logic [1:0]     fetch_sym;
  logic           fetch_aux;
  logic [15:0]    fetch_dur_raw;
  logic [DUR_W-1:0] fetch_dur;
  logic [3:0]     fetch_presc;
  logic [TW-1:0]  fetch_len, fetch_len_m1;

  assign at_end   = (pc_q == end_pc_q);
  assign do_loop  = ctrl_q[1] && ((repeat_q == 8'd0) || (loops_left_q != 8'd0));
  assign pc_adv   = at_end ? loop_pc_q : pc_q + PCW'(1);
  assign fetch_pc = (state_q == RUN) ? pc_adv : pc_q;

  always_comb begin
    fetch_word    = mem_q[fetch_pc[PCW-1:4]];
    fetch_sym     = fetch_word[{fetch_pc[3:0], 1'b0} +: 2];
    fetch_aux     = (fetch_pc < PCW'(8)) && aux_mask_q[fetch_pc[2:0]];
    fetch_presc   = fetch_aux ? aux_presc_q : main_presc_q;
    fetch_dur_raw = '0;
    case (fetch_sym)
      2'd0: fetch_dur_raw = fetch_aux ? aux_low_q[15:0]   : main_low_q[15:0];
      2'd1: fetch_dur_raw = fetch_aux ? aux_low_q[31:16]  : main_low_q[31:16];
      2'd2: fetch_dur_raw = fetch_aux ? aux_high_q[15:0]  : main_high_q[15:0];
      default: fetch_dur_raw = fetch_aux ? aux_high_q[31:16] : main_high_q[31:16];
    endcase
    fetch_dur    = fetch_dur_raw[DUR_W-1:0];
    fetch_len    = (TW'(fetch_dur) + TW'(1)) << fetch_presc;
    fetch_len_m1 = fetch_len - TW'(1);
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    loops_left_d = loops_left_q;
    level_d      = level_q;
    timer_d      = timer_q;
    set_done     = 1'b0;
    set_loop     = 1'b0;
    start_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start_edge) begin
          state_d      = FETCH;
          loops_left_d = repeat_q;
          start_clr    = 1'b1;
        end
      end
      FETCH: begin
        level_d = fetch_sym[1];
        timer_d = fetch_len_m1;
        state_d = RUN;
      end
      RUN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (at_end && !do_loop) begin
          state_d  = IDLE;
          pc_d     = '0;
          set_done = 1'b1;
        end else begin
          pc_d    = pc_adv;
          level_d = fetch_sym[1];
          timer_d = fetch_len_m1;
          if (at_end) begin
            set_loop = 1'b1;
            if (repeat_q != 8'd0) loops_left_d = loops_left_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Clearing start aborts silently from any state.
    if (!start) begin
      state_d      = IDLE;
      pc_d         = '0;
      loops_left_d = loops_left_q;
      set_done     = 1'b0;
      set_loop     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      loops_left_q <= '0;
      level_q      <= 1'b0;
      timer_q      <= '0;
      start_prev_q <= 1'b0;
      done_q       <= 1'b0;
      loop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      loops_left_q <= loops_left_d;
      level_q      <= level_d;
      timer_q      <= timer_d;
      start_prev_q <= start;
      // A flag being set wins over a simultaneous write-1-to-clear.
      done_q       <= set_done | (done_q & ~clr_done & ~start_clr);
      loop_q       <= set_loop | (loop_q & ~clr_loop & ~start_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_cnt_q <= '0;
      car_q     <= 1'b0;
    end else if (!busy) begin
      car_cnt_q <= '0;
      car_q     <= 1'b0;
    end else if (car_cnt_q == half_period_q) begin
      car_cnt_q <= '0;
      car_q     <= ~car_q;
    end else begin
      car_cnt_q <= car_cnt_q + 16'd1;
    end
  end

  logic mod, pulse;
  assign mod            = ctrl_q[4] ? (level_q & car_q) : level_q;
  assign pulse          = (busy ? mod : ctrl_q[2]) ^ ctrl_q[3];
  assign uo_out         = {5'b0, pulse, busy & car_q, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = (done_q & ctrl_q[5]) | (loop_q & ctrl_q[6]);

  always_comb begin
    data_out = '0;
    case (reg_sel)
      4'd0: data_out[6:0] = ctrl_q;
      4'd1: begin
        data_out[PCW-1:0]  = end_pc_q;
        data_out[8 +: PCW] = loop_pc_q;
        data_out[23:16]    = repeat_q;
        data_out[27:24]    = main_presc_q;
        data_out[31:28]    = aux_presc_q;
      end
      4'd2: data_out[23:0] = {aux_mask_q, half_period_q};
      4'd3: data_out = main_low_q;
      4'd4: data_out = main_high_q;
      4'd5: data_out = aux_low_q;
      4'd6: data_out = aux_high_q;
      4'd7: begin
        data_out[0]        = busy;
        data_out[1]        = done_q;
        data_out[2]        = loop_q;
        data_out[8 +: PCW] = pc_q;
        data_out[23:16]    = loops_left_q;
      end
      default: data_out = mem_q[address[AW+1:2]];
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{ui_in, data_read_n, address[1:0], fetch_dur_raw};

endmodule

// File: tb/tb_tqvp_hx2003_pulse_transmitter_gen2.sv
`timescale 1ns/1ps
// Directed and randomised bench; expected waveforms come from a flat symbol-list
// model built from the program rules (pc walk, loop rule, duration tables).
module tb_tqvp_hx2003_pulse_transmitter_gen2;
  localparam int DEPTH_WORDS = 8;
  localparam int DUR_W       = 8;
  localparam int NSYM        = DEPTH_WORDS * 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'd0;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'd0;
  logic [31:0] data_in = 32'd0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_checks = 0;
  int n_errors = 0;

  tqvp_hx2003_pulse_transmitter_gen2 #(.DEPTH_WORDS(DEPTH_WORDS), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Program configuration shared by the loader and the model
  logic [31:0] c_data [DEPTH_WORDS];
  logic        c_loop_en, c_idle, c_inv, c_car_en, c_irq_done, c_irq_loop;
  int          c_end, c_loop_pc, c_repeat, c_mpresc, c_apresc, c_half, c_mask;
  logic [31:0] c_mlow, c_mhigh, c_alow, c_ahigh;

  typedef struct packed { logic o; logic b; logic c; logic p; } exp_t;
  exp_t expq[$];
  int   m_left;
  logic m_loop;

  task automatic clear_cfg();
    for (int i = 0; i < DEPTH_WORDS; i++) c_data[i] = 32'd0;
    {c_loop_en, c_idle, c_inv, c_car_en, c_irq_done, c_irq_loop} = 6'd0;
    c_end = 0; c_loop_pc = 0; c_repeat = 0; c_mpresc = 0; c_apresc = 0; c_half = 0; c_mask = 0;
    c_mlow = 0; c_mhigh = 0; c_alow = 0; c_ahigh = 0;
  endtask

  function automatic logic [31:0] ctrl_word(input logic start);
    return {25'd0, c_irq_loop, c_irq_done, c_car_en, c_inv, c_idle, c_loop_en, start};
  endfunction

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; data_in = d; data_write_n = 2'b10;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    address = a; data_read_n = 2'b10;
    #1 d = data_out;
    data_read_n = 2'b11;
  endtask

  task automatic load_config();
    bus_write(6'h00, ctrl_word(1'b0));
    for (int i = 0; i < DEPTH_WORDS; i++) bus_write(6'(32 + 4 * i), c_data[i]);
    bus_write(6'h04, {4'(c_apresc), 4'(c_mpresc), 8'(c_repeat), 1'b0, 7'(c_loop_pc), 1'b0, 7'(c_end)});
    bus_write(6'h08, {8'd0, 8'(c_mask), 16'(c_half)});
    bus_write(6'h0C, c_mlow);
    bus_write(6'h10, c_mhigh);
    bus_write(6'h14, c_alow);
    bus_write(6'h18, c_ahigh);
  endtask

  // Flat expansion: 2 idle cycles of start latency, every symbol cycle, 3 idle cycles after done.
  task automatic build_expected();
    int pc, k, w, s, d, len, presc;
    logic aux, lvl, car, idle_o;
    logic [31:0] tbl;
    exp_t e;
    expq.delete();
    idle_o = c_idle ^ c_inv;
    for (int i = 0; i < 2; i++) begin
      e.o = idle_o; e.b = 1'b0; e.c = 1'b0; e.p = 1'b0; expq.push_back(e);
    end
    pc = 0; k = 0; m_left = c_repeat; m_loop = 1'b0;
    for (int guard = 0; guard < 1000; guard++) begin
      w     = pc / 16;
      s     = int'((c_data[w] >> (2 * (pc % 16))) & 32'h3);
      aux   = (pc < 8) && c_mask[pc];
      tbl   = (s < 2) ? (aux ? c_alow : c_mlow) : (aux ? c_ahigh : c_mhigh);
      d     = (s % 2 == 0) ? int'(tbl[15:0]) : int'(tbl[31:16]);
      d     = d % (1 << DUR_W);
      presc = aux ? c_apresc : c_mpresc;
      len   = (d + 1) << presc;
      lvl   = (s >= 2);
      for (int c = 0; c < len; c++) begin
        car = ((k / (c_half + 1)) % 2) == 1;
        e.o = (c_car_en ? (lvl & car) : lvl) ^ c_inv;
        e.b = 1'b1; e.c = car; e.p = 1'b0;
        expq.push_back(e);
        k++;
      end
      if (pc == c_end) begin
        if (c_loop_en && (c_repeat == 0 || m_left != 0)) begin
          pc = c_loop_pc;
          if (c_repeat != 0) m_left--;
          m_loop = 1'b1;
        end else begin
          break;
        end
      end else begin
        pc = (pc + 1) % NSYM;
      end
    end
    for (int i = 0; i < 3; i++) begin
      e.o = idle_o; e.b = 1'b0; e.c = 1'b0; e.p = 1'b1; expq.push_back(e);
    end
  endtask

  task automatic run_check(input string name);
    logic [31:0] st;
    exp_t e;
    build_expected();
    load_config();
    bus_write(6'h00, ctrl_word(1'b1));
    address = 6'h1C;
    for (int i = 0; i < expq.size(); i++) begin
      @(negedge clk);
      e = expq[i];
      chk($sformatf("%s/out[%0d]", name, i), 32'(uo_out[2]), 32'(e.o));
      chk($sformatf("%s/car[%0d]", name, i), 32'(uo_out[1]), 32'(e.c));
      chk($sformatf("%s/busy[%0d]", name, i), 32'(data_out[0]), 32'(e.b));
      if (e.p) chk($sformatf("%s/done[%0d]", name, i), 32'(data_out[1]), 32'd1);
    end
    bus_read(6'h1C, st);
    chk({name, "/loopflag"}, 32'(st[2]), 32'(m_loop));
    chk({name, "/loops_left"}, 32'(st[23:16]), 32'(m_left[7:0]));
    chk({name, "/pc_idle"}, 32'(st[14:8]), 32'd0);
    chk({name, "/irq"}, 32'(user_interrupt), 32'(c_irq_done | (m_loop & c_irq_loop)));
    chk({name, "/other_bits"}, 32'(uo_out & 8'hF9), 32'd0);
  endtask

  logic [31:0] rd;

  initial begin
    clear_cfg();
    #23 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst/uo_out", 32'(uo_out), 32'd0);
    chk("rst/irq", 32'(user_interrupt), 32'd0);
    chk("rst/ready", 32'(data_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus_read(6'(4 * i), rd);
      chk($sformatf("rst/reg%0d", i), rd, 32'd0);
    end

    // Readback and narrow-write masking
    bus_write(6'h00, 32'hFFFF_FFFE); bus_read(6'h00, rd); chk("rb/ctrl", rd, 32'h0000_007E);
    bus_write(6'h04, 32'hFFFF_FFFF); bus_read(6'h04, rd); chk("rb/prog", rd, 32'hFFFF_7F7F);
    bus_write(6'h08, 32'hFFFF_FFFF); bus_read(6'h08, rd); chk("rb/carrier", rd, 32'h00FF_FFFF);
    bus_write(6'h0C, 32'h1234_5678); bus_read(6'h0C, rd); chk("rb/main_low", rd, 32'h1234_5678);
    bus_write(6'h2C, 32'hCAFE_F00D); bus_read(6'h2C, rd); chk("rb/data3", rd, 32'hCAFE_F00D);
    @(posedge clk); #1;
    address = 6'h0C; data_in = 32'hDEAD_BEEF; data_write_n = 2'b00;
    @(posedge clk); #1;
    data_write_n = 2'b11;
    bus_read(6'h0C, rd); chk("rb/byte_write_ignored", rd, 32'h1234_5678);
    bus_write(6'h00, 32'd0);

    // Basic run
    clear_cfg();
    c_data[0] = 32'h0000_0002; c_end = 1; c_mlow = 32'd3; c_mhigh = 32'd1;
    run_check("basic");

    // start still 1 after done must not restart
    bus_write(6'h00, ctrl_word(1'b1));
    repeat (5) @(negedge clk);
    bus_read(6'h1C, rd); chk("norestart/busy", 32'(rd[0]), 32'd0);

    // Bounded loop with loop interrupt, then write-1-to-clear
    clear_cfg();
    c_data[0] = 32'h0000_00E4; c_end = 3; c_loop_pc = 2; c_repeat = 2; c_loop_en = 1'b1;
    c_irq_loop = 1'b1; c_mlow = {16'd1, 16'd0}; c_mhigh = {16'd3, 16'd2};
    run_check("loop");
    bus_write(6'h1C, 32'h0000_0004);
    bus_read(6'h1C, rd);
    chk("loop/irq_cleared", 32'(user_interrupt), 32'd0);
    chk("loop/flag_cleared", 32'(rd[2]), 32'd0);
    chk("loop/done_kept", 32'(rd[1]), 32'd1);

    // Auxiliary table with prescaler on symbol 0 only
    clear_cfg();
    c_data[0] = 32'h0000_0007; c_end = 1; c_mask = 1; c_apresc = 2; c_ahigh = 32'h0000_0009;
    c_mhigh = {16'd5, 16'd1}; c_mlow = {16'd2, 16'd0}; c_mpresc = 0;
    run_check("aux");

    // Carrier with inversion
    clear_cfg();
    for (int i = 0; i < DEPTH_WORDS; i++) c_data[i] = 32'hAAAA_AAAA;
    c_end = 3; c_mhigh = 32'd2; c_half = 1; c_car_en = 1'b1; c_inv = 1'b1; c_irq_done = 1'b1;
    run_check("carrier");

    // Abort mid-run
    clear_cfg();
    c_data[0] = 32'h0000_0AA2; c_end = 5; c_mlow = 32'd10; c_mhigh = 32'd10; c_irq_done = 1'b1;
    load_config();
    bus_write(6'h00, ctrl_word(1'b1));
    repeat (8) @(posedge clk);
    bus_write(6'h00, ctrl_word(1'b0));
    @(posedge clk); #1;
    bus_read(6'h1C, rd);
    chk("abort/busy", 32'(rd[0]), 32'd0);
    chk("abort/done", 32'(rd[1]), 32'd0);
    chk("abort/out", 32'(uo_out[2]), 32'd0);
    chk("abort/irq", 32'(user_interrupt), 32'd0);

    // Clear written on the very cycle done is set: done must survive
    clear_cfg();
    c_data[0] = 32'h0000_0002; c_end = 1; c_mlow = 32'd3; c_mhigh = 32'd1;
    load_config();
    bus_write(6'h00, ctrl_word(1'b1));
    repeat (6) @(posedge clk);
    bus_write(6'h1C, 32'h0000_0006);
    bus_read(6'h1C, rd);
    chk("race/done", 32'(rd[1]), 32'd1);
    bus_write(6'h1C, 32'h0000_0002);
    bus_read(6'h1C, rd);
    chk("race/cleared", 32'(rd[1]), 32'd0);

    // Infinite loop keeps running
    clear_cfg();
    c_data[0] = 32'h0000_00E4; c_end = 3; c_loop_pc = 2; c_loop_en = 1'b1; c_mhigh = 32'd1;
    load_config();
    bus_write(6'h00, ctrl_word(1'b1));
    repeat (100) @(posedge clk);
    bus_read(6'h1C, rd);
    chk("inf/busy", 32'(rd[0]), 32'd1);
    chk("inf/loop", 32'(rd[2]), 32'd1);
    chk("inf/done", 32'(rd[1]), 32'd0);
    chk("inf/loops_left", 32'(rd[23:16]), 32'd0);
    bus_write(6'h00, ctrl_word(1'b0));

    // Randomised programs
    for (int t = 0; t < 12; t++) begin
      clear_cfg();
      for (int i = 0; i < DEPTH_WORDS; i++) c_data[i] = $urandom;
      c_end      = $urandom_range(0, 12);
      c_loop_pc  = $urandom_range(0, c_end);
      c_repeat   = $urandom_range(1, 3);
      c_loop_en  = 1'($urandom_range(0, 1));
      c_idle     = 1'($urandom_range(0, 1));
      c_inv      = 1'($urandom_range(0, 1));
      c_car_en   = 1'($urandom_range(0, 1));
      c_irq_done = 1'($urandom_range(0, 1));
      c_irq_loop = 1'($urandom_range(0, 1));
      c_half     = $urandom_range(0, 3);
      c_mask     = $urandom_range(0, 255);
      c_mpresc   = $urandom_range(0, 2);
      c_apresc   = $urandom_range(0, 2);
      c_mlow  = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 4))};
      c_mhigh = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 4))};
      c_alow  = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 4))};
      c_ahigh = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 4))};
      run_check($sformatf("rand%0d", t));
    end

    // Asynchronous reset in the middle of a high symbol
    clear_cfg();
    c_data[0] = 32'hAAAA_AAAA; c_end = 5; c_mhigh = 32'd20;
    load_config();
    bus_write(6'h00, ctrl_word(1'b1));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midreset/before", 32'(uo_out[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("midreset/uo_out", 32'(uo_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_read(6'(4 * i), rd);
      chk($sformatf("midreset/reg%0d", i), rd, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
